// File: rtl/uart_rx_core_if.sv
// Byte-side handshake bundle of the UART receiver: one-entry valid/ready output
// register plus the framing-error and overrun pulses.
interface uart_rx_core_if;
  logic [7:0] rdata;
  logic       rvalid;
  logic       rready;
  logic       ferr;
  logic       ovf;

  modport master (output rdata, rvalid, ferr, ovf, input rready);
  modport slave  (input rdata, rvalid, ferr, ovf, output rready);
endinterface

// File: rtl/uart_rx_core.sv
// UART receive front-end: 2-FF synchroniser, 8N1 framer (8E1 when UART_RX_PARITY_EN
// is defined), one-entry valid/ready output register with ferr/ovf pulses.
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic           CLK,
  input  logic           RSTN,
  input  logic           UART_RX,
  uart_rx_core_if.master rx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  logic             rx_meta_p0;
  logic             rxs;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic [7:0]       rdata_q;
  logic             rvalid_q;
  logic             ferr_q;
  logic             ovf_q;
  logic             tick;
  logic             stop_samp;
  logic             frame_good;
  logic             commit;
`ifdef UART_RX_PARITY_EN
  logic             par_err;
`endif

  // Stage boundary: raw pin -> metastability FF -> rxs, both idle-high.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rx_meta_p0 <= 1'b1;
      rxs        <= 1'b1;
    end else begin
      rx_meta_p0 <= UART_RX;
      rxs        <= rx_meta_p0;
    end
  end

  assign tick      = (cnt == '0);
  assign stop_samp = (state == S_STOP) && tick;
`ifdef UART_RX_PARITY_EN
  assign frame_good = rxs && !par_err;
`else
  assign frame_good = rxs;
`endif
  assign commit = stop_samp && frame_good;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err  <= 1'b0;
`endif
    end else begin
      ferr_q <= 1'b0;
      ovf_q  <= 1'b0;

      // A simultaneous accept frees the register, so the new byte may replace it.
      if (commit) begin
        if (!rvalid_q || rx.rready) begin
          rdata_q  <= shreg;
          rvalid_q <= 1'b1;
        end else begin
          ovf_q <= 1'b1;
        end
      end else if (rvalid_q && rx.rready) begin
        rvalid_q <= 1'b0;
      end

      if (stop_samp && !frame_good) ferr_q <= 1'b1;

      case (state)
        S_IDLE: begin
          if (!rxs) begin
            state <= S_START;
            cnt   <= HALF_RELOAD;
`ifdef UART_RX_PARITY_EN
            par_err <= 1'b0;
`endif
          end
        end
        S_START: begin
          if (tick) begin
            if (rxs) begin
              state <= S_IDLE;
            end else begin
              state   <= S_DATA;
              cnt     <= FULL_RELOAD;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (tick) begin
            cnt     <= FULL_RELOAD;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            par_err <= ((^shreg) != rxs);
            cnt     <= FULL_RELOAD;
            state   <= S_STOP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif
        // Leaving at the stop-bit centre gives half a bit of slack to resync on the next start.
        S_STOP: begin
          if (tick) begin
            state <= rxs ? S_IDLE : S_WAIT_HIGH;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          if (rxs) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Payload shift register carries no reset; it is only observed after a full frame.
  always_ff @(posedge CLK) begin
    if (state == S_DATA && tick) shreg[bit_idx] <= rxs;
  end

  assign rx.rdata  = rdata_q;
  assign rx.rvalid = rvalid_q;
  assign rx.ferr   = ferr_q;
  assign rx.ovf    = ovf_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: frame-level reference model with per-cycle compare plus
// directed literal checks; define UART_RX_PARITY_EN to exercise the 8E1 build.
module tb_uart_rx_core;
  localparam int C = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif

  logic CLK     = 1'b0;
  logic RSTN    = 1'b0;
  logic UART_RX = 1'b1;

  uart_rx_core_if bus ();

  uart_rx_core #(.CLKS_PER_BIT(C)) dut (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .UART_RX (UART_RX),
    .rx      (bus.master)
  );

  always #5 CLK = ~CLK;

  // Frame outcomes: decision edge, byte, and whether the frame is bad.
  int         ev_due  [0:255];
  logic [7:0] ev_data [0:255];
  bit         ev_err  [0:255];
  int         ev_wr = 0;
  int         ev_rd = 0;

  int         cyc = 0;
  logic       exp_rvalid = 1'b0;
  logic [7:0] exp_rdata  = 8'h00;
  logic       exp_ferr   = 1'b0;
  logic       exp_ovf    = 1'b0;

  int   n_chk = 0;
  int   n_pass = 0;
  int   n_rv = 0;
  int   n_ferr = 0;
  int   n_ovf = 0;
  logic rand_rdy = 1'b0;

  // Output register model: one slot, fed by frame outcomes at their decision edge.
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (!RSTN) begin
      exp_rvalid <= 1'b0;
      exp_rdata  <= 8'h00;
      exp_ferr   <= 1'b0;
      exp_ovf    <= 1'b0;
    end else begin
      exp_ferr <= 1'b0;
      exp_ovf  <= 1'b0;
      if (ev_rd < ev_wr && ev_due[ev_rd] == cyc + 1) begin
        ev_rd <= ev_rd + 1;
        if (ev_err[ev_rd]) begin
          exp_ferr <= 1'b1;
          if (exp_rvalid && bus.rready) exp_rvalid <= 1'b0;
        end else if (!exp_rvalid || bus.rready) begin
          exp_rdata  <= ev_data[ev_rd];
          exp_rvalid <= 1'b1;
        end else begin
          exp_ovf <= 1'b1;
        end
      end else if (exp_rvalid && bus.rready) begin
        exp_rvalid <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge CLK);
      if (RSTN) begin
        check("rvalid", 32'(bus.rvalid), 32'(exp_rvalid));
        check("rdata",  32'(bus.rdata),  32'(exp_rdata));
        check("ferr",   32'(bus.ferr),   32'(exp_ferr));
        check("ovf",    32'(bus.ovf),    32'(exp_ovf));
        if (bus.rvalid) n_rv++;
        if (bus.ferr)   n_ferr++;
        if (bus.ovf)    n_ovf++;
      end
    end
  endtask

  task automatic rdy_loop();
    forever begin
      @(negedge CLK);
      if (rand_rdy) bus.rready = 1'($urandom_range(0, 1));
    end
  endtask

  // Start bit falls at this negedge; the DUT sees it 3 edges later, then half a bit + NB bits.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_ok,
                            input int hold_low, input bit pulse_rdy);
    int due;
    @(negedge CLK);
    due = cyc + 3 + C / 2 + NB * C;
    ev_due[ev_wr]  = due;
    ev_data[ev_wr] = b;
    ev_err[ev_wr]  = !stop_bit || !par_ok;
    ev_wr++;
    UART_RX = 1'b0;
    repeat (C) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      UART_RX = b[i];
      repeat (C) @(negedge CLK);
    end
`ifdef UART_RX_PARITY_EN
    UART_RX = (^b) ^ !par_ok;
    repeat (C) @(negedge CLK);
`endif
    UART_RX = stop_bit;
    for (int k = 0; k < C; k++) begin
      if (pulse_rdy) bus.rready = (cyc == due - 1);
      @(negedge CLK);
    end
    if (pulse_rdy) bus.rready = 1'b0;
    repeat (hold_low) @(negedge CLK);
    UART_RX = 1'b1;
  endtask

  task automatic run_tests();
    int r0;
    int f0;
    int o0;
    bus.rready = 1'b0;
    repeat (4) @(negedge CLK);
    check("reset_rdata",  32'(bus.rdata),  32'h00);
    check("reset_rvalid", 32'(bus.rvalid), 32'h0);
    check("reset_ferr",   32'(bus.ferr),   32'h0);
    check("reset_ovf",    32'(bus.ovf),    32'h0);
    RSTN = 1'b1;
    repeat (2 * C) @(negedge CLK);

    // Single byte with consumer always ready.
    bus.rready = 1'b1;
    r0 = n_rv;
    send_frame(8'hA5, 1'b1, 1'b1, 0, 1'b0);
    repeat (C) @(negedge CLK);
    check("t1_rvalid_cycles", 32'(n_rv - r0), 32'd1);
    check("t1_rdata", 32'(bus.rdata), 32'hA5);

    // Overrun: second byte dropped while the first is held.
    bus.rready = 1'b0;
    o0 = n_ovf;
    send_frame(8'h3C, 1'b1, 1'b1, 0, 1'b0);
    send_frame(8'h55, 1'b1, 1'b1, 0, 1'b0);
    repeat (4) @(negedge CLK);
    check("t2_rdata", 32'(bus.rdata), 32'h3C);
    check("t2_rvalid", 32'(bus.rvalid), 32'h1);
    check("t2_ovf_pulses", 32'(n_ovf - o0), 32'd1);
    bus.rready = 1'b1;
    @(negedge CLK);
    check("t2_rvalid_fall", 32'(bus.rvalid), 32'h0);

    // Short low glitch is rejected at the start-bit centre.
    r0 = n_rv;
    f0 = n_ferr;
    UART_RX = 1'b0;
    repeat (5) @(negedge CLK);
    UART_RX = 1'b1;
    repeat (2 * C) @(negedge CLK);
    check("t3_glitch_rvalid", 32'(n_rv - r0), 32'd0);
    check("t3_glitch_ferr", 32'(n_ferr - f0), 32'd0);
    send_frame(8'h81, 1'b1, 1'b1, 0, 1'b0);
    repeat (C) @(negedge CLK);
    check("t3_rdata", 32'(bus.rdata), 32'h81);

    // Bad stop bit followed by a long break.
    f0 = n_ferr;
    r0 = n_rv;
    send_frame(8'h7E, 1'b0, 1'b1, 40 * C, 1'b0);
    repeat (2 * C) @(negedge CLK);
    check("t4_ferr_pulses", 32'(n_ferr - f0), 32'd1);
    check("t4_rvalid", 32'(n_rv - r0), 32'd0);
    send_frame(8'h12, 1'b1, 1'b1, 0, 1'b0);
    repeat (C) @(negedge CLK);
    check("t4_rdata", 32'(bus.rdata), 32'h12);

    // Accept and commit on the same edge: new byte replaces the old one.
    bus.rready = 1'b0;
    o0 = n_ovf;
    send_frame(8'h00, 1'b1, 1'b1, 0, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b1, 0, 1'b1);
    repeat (4) @(negedge CLK);
    check("t5_rdata", 32'(bus.rdata), 32'hFF);
    check("t5_rvalid", 32'(bus.rvalid), 32'h1);
    check("t5_ovf", 32'(n_ovf - o0), 32'd0);
    bus.rready = 1'b1;
    repeat (2) @(negedge CLK);

`ifdef UART_RX_PARITY_EN
    f0 = n_ferr;
    send_frame(8'h01, 1'b1, 1'b0, 0, 1'b0);
    repeat (C) @(negedge CLK);
    check("t6_parity_ferr", 32'(n_ferr - f0), 32'd1);
    send_frame(8'h01, 1'b1, 1'b1, 0, 1'b0);
    repeat (C) @(negedge CLK);
    check("t6_parity_rdata", 32'(bus.rdata), 32'h01);
`endif

    // Asynchronous reset in the middle of a data bit.
    bus.rready = 1'b0;
    send_frame(8'hC3, 1'b1, 1'b1, 0, 1'b0);
    repeat (4) @(negedge CLK);
    UART_RX = 1'b0;
    repeat (C) @(negedge CLK);
    UART_RX = 1'b1;
    repeat (C) @(negedge CLK);
    UART_RX = 1'b0;
    repeat (C / 2) @(negedge CLK);
    @(posedge CLK);
    #2;
    RSTN = 1'b0;
    UART_RX = 1'b1;
    #1;
    check("rst_rvalid", 32'(bus.rvalid), 32'h0);
    check("rst_rdata",  32'(bus.rdata),  32'h00);
    check("rst_ferr",   32'(bus.ferr),   32'h0);
    check("rst_ovf",    32'(bus.ovf),    32'h0);
    repeat (3) @(negedge CLK);
    RSTN = 1'b1;
    repeat (C) @(negedge CLK);
    bus.rready = 1'b1;
    r0 = n_rv;
    send_frame(8'h5A, 1'b1, 1'b1, 0, 1'b0);
    repeat (C) @(negedge CLK);
    check("rst_next_rdata", 32'(bus.rdata), 32'h5A);
    check("rst_next_rvalid_cycles", 32'(n_rv - r0), 32'd1);

    // Random bytes, random stop/parity faults and random consumer backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 24; i++) begin
      logic [7:0] b;
      logic       sb;
      logic       po;
      b  = 8'($urandom);
      sb = ($urandom_range(0, 7) != 0);
      po = 1'b1;
`ifdef UART_RX_PARITY_EN
      po = ($urandom_range(0, 7) != 0);
`endif
      send_frame(b, sb, po, 0, 1'b0);
      repeat ($urandom_range(2, 30)) @(negedge CLK);
    end
    rand_rdy = 1'b0;
    bus.rready = 1'b1;
    repeat (2 * C) @(negedge CLK);
  endtask

  initial begin
    fork
      compare_loop();
      rdy_loop();
      run_tests();
      begin
        #3000000;
        n_chk++;
        $display("FAIL timeout: bench did not complete, cycle %0d", cyc);
      end
    join_any
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
